// File: rtl/load_store_unit_if.sv
// Request/response bundle between the control unit (master) and the load/store unit (slave).
// Requests are accepted only while lsu_busy is low; lsu_done pulses once per request.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              lsu_req;
  logic              lsu_wr;
  logic [2:0]        lsu_funct3;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_busy;
  logic              lsu_done;
  logic [31:0]       lsu_rdata;
  logic [1:0]        lsu_err;

  modport master (
    output lsu_req, lsu_wr, lsu_funct3, lsu_addr, lsu_wdata,
    input  lsu_busy, lsu_done, lsu_rdata, lsu_err
  );

  modport slave (
    input  lsu_req, lsu_wr, lsu_funct3, lsu_addr, lsu_wdata,
    output lsu_busy, lsu_done, lsu_rdata, lsu_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-memory access unit: byte/half/word loads and stores on an internal array, done after WAIT_STATES+2 edges (1 on error).
// No queueing: lsu_req is sampled only in IDLE and ignored while busy, including the DONE cycle.
module load_store_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic             lsu_clk,
  input  logic             lsu_rst,
  load_store_unit_if.slave lsu
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             wr_q;
  logic [2:0]       f3_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       err_q;

  logic [ADDR_W-1:0] addr_in;
  logic              funct3_bad, misaligned, out_of_range;
  logic [1:0]        req_err;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword, load_ext, wword;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [3:0]       be;

  // Request checks are evaluated on the live inputs so an error can skip straight to DONE.
  assign addr_in      = lsu.lsu_addr;
  assign funct3_bad   = (lsu.lsu_funct3[1:0] == 2'b11) ||
                        (lsu.lsu_funct3[2] && (lsu.lsu_wr || lsu.lsu_funct3[1]));
  assign misaligned   = ((lsu.lsu_funct3[1:0] == 2'b01) && addr_in[0]) ||
                        ((lsu.lsu_funct3[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
  assign out_of_range = |(addr_in >> (IDX_W + 2));
  assign req_err      = {out_of_range, funct3_bad | misaligned};

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lsu.lsu_req) begin
          if (|req_err)             state_d = ST_DONE;
          else if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                      state_d = ST_ACCESS;
        end
      end
      ST_WAIT:   if (cnt_q == 4'd0) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 2'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (lsu.lsu_req) begin
            wr_q    <= lsu.lsu_wr;
            f3_q    <= lsu.lsu_funct3;
            addr_q  <= addr_in[IDX_W+1:0];
            wdata_q <= lsu.lsu_wdata;
            rdata_q <= 32'd0;
            err_q   <= req_err;
            cnt_q   <= WAIT_LOAD;
          end
        end
        ST_WAIT:   if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        ST_ACCESS: if (!wr_q) rdata_q <= load_ext;
        default: ;
      endcase
    end
  end

  assign idx      = addr_q[IDX_W+1:2];
  assign rword    = mem[idx];
  assign byte_sel = rword[8*addr_q[1:0] +: 8];
  assign half_sel = addr_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_ext = rword;
    unique case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = rword;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  // Array is never cleared; reset only blocks a write that would land in the same edge.
  always_ff @(posedge lsu_clk) begin
    if (!lsu_rst && (state_q == ST_ACCESS) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign lsu.lsu_busy  = (state_q != ST_IDLE);
  assign lsu.lsu_done  = (state_q == ST_DONE);
  assign lsu.lsu_rdata = rdata_q;
  assign lsu.lsu_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Drives three load_store_unit instances (WAIT_STATES 1, 0, 5) with identical requests and
// checks each against a byte-level memory model.
module tb_load_store_unit;
  localparam int DEPTH = 256;
  localparam int WS [3] = '{1, 0, 5};

  logic        clk = 1'b0;
  logic        rst [3];
  logic        req, wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;

  logic        busy_o [3];
  logic        done_o [3];
  logic [31:0] rdata_o [3];
  logic [1:0]  err_o [3];

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus0 ();
  load_store_unit_if #(.ADDR_W(32)) bus1 ();
  load_store_unit_if #(.ADDR_W(32)) bus2 ();

  assign bus0.lsu_req = req;    assign bus1.lsu_req = req;    assign bus2.lsu_req = req;
  assign bus0.lsu_wr = wr;      assign bus1.lsu_wr = wr;      assign bus2.lsu_wr = wr;
  assign bus0.lsu_funct3 = funct3; assign bus1.lsu_funct3 = funct3; assign bus2.lsu_funct3 = funct3;
  assign bus0.lsu_addr = addr;  assign bus1.lsu_addr = addr;  assign bus2.lsu_addr = addr;
  assign bus0.lsu_wdata = wdata; assign bus1.lsu_wdata = wdata; assign bus2.lsu_wdata = wdata;

  assign busy_o[0] = bus0.lsu_busy;  assign busy_o[1] = bus1.lsu_busy;  assign busy_o[2] = bus2.lsu_busy;
  assign done_o[0] = bus0.lsu_done;  assign done_o[1] = bus1.lsu_done;  assign done_o[2] = bus2.lsu_done;
  assign rdata_o[0] = bus0.lsu_rdata; assign rdata_o[1] = bus1.lsu_rdata; assign rdata_o[2] = bus2.lsu_rdata;
  assign err_o[0] = bus0.lsu_err;    assign err_o[1] = bus1.lsu_err;    assign err_o[2] = bus2.lsu_err;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS[0]), .ADDR_W(32))
    u0 (.lsu_clk(clk), .lsu_rst(rst[0]), .lsu(bus0));
  load_store_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS[1]), .ADDR_W(32))
    u1 (.lsu_clk(clk), .lsu_rst(rst[1]), .lsu(bus1));
  load_store_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS[2]), .ADDR_W(32))
    u2 (.lsu_clk(clk), .lsu_rst(rst[2]), .lsu(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: decode legality and size from the ISA tables, then move bytes little-endian.
  task automatic model(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       output bit [1:0] e, output bit [31:0] rd);
    int nbytes, lane;
    bit legal;
    bit [31:0] v, mask;
    bit [7:0] wi;
    legal  = w ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e[0]   = !legal || ((a % nbytes) != 0);
    e[1]   = (a >= 32'(4 * DEPTH));
    rd     = 32'd0;
    if (e == 2'b00) begin
      wi   = a[9:2];
      lane = int'(a[1:0]);
      if (w) begin
        for (int b = 0; b < nbytes; b++) mdl[wi][8*(lane+b) +: 8] = wd[8*b +: 8];
      end else begin
        v    = mdl[wi] >> (8 * lane);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
        rd   = v;
      end
    end
  endtask

  task automatic xact(input string tag, input bit w, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd);
    bit [1:0]  e;
    bit [31:0] rd;
    int lat [3];
    int bcnt [3];
    int cyc, exp_lat;
    model(w, f3, a, wd, e, rd);
    req = 1'b1; wr = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    lat  = '{0, 0, 0};
    bcnt = '{0, 0, 0};
    cyc  = 1;
    while (cyc <= 20) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_o[i]) bcnt[i]++;
        if (done_o[i] && lat[i] == 0) lat[i] = cyc;
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && !busy_o[0] && !busy_o[1] && !busy_o[2]) break;
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      exp_lat = (e != 2'b00) ? 1 : WS[i] + 2;
      chk($sformatf("%s latency u%0d", tag, i), 32'(lat[i]), 32'(exp_lat));
      chk($sformatf("%s busy_cycles u%0d", tag, i), 32'(bcnt[i]), 32'(exp_lat));
      chk($sformatf("%s err u%0d", tag, i), 32'(err_o[i]), 32'(e));
      chk($sformatf("%s rdata u%0d", tag, i), rdata_o[i], rd);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp_rd, input logic [1:0] exp_err);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s spec_rdata u%0d", tag, i), rdata_o[i], exp_rd);
      chk($sformatf("%s spec_err u%0d", tag, i), 32'(err_o[i]), 32'(exp_err));
    end
  endtask

  initial begin
    int t [3][3];
    int nd [3];
    bit        rw;
    bit [2:0]  rf3;
    bit [31:0] ra;
    int sel;

    req = 1'b0; wr = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset busy u%0d", i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("reset done u%0d", i), 32'(done_o[i]), 32'd0);
      chk($sformatf("reset rdata u%0d", i), rdata_o[i], 32'd0);
      chk($sformatf("reset err u%0d", i), 32'(err_o[i]), 32'd0);
      rst[i] = 1'b0;
    end

    // Give every word the random stimulus touches a defined value.
    for (int wi = 0; wi < 16; wi++) xact("init", 1'b1, 3'b010, 32'(wi * 4), $urandom);
    xact("init_top", 1'b1, 3'b010, 32'h3FC, $urandom);

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk_all("sw10", 32'd0, 2'b00);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'd0);
    chk_all("lw10", 32'hDEAD_BEEF, 2'b00);
    xact("lb13", 1'b0, 3'b000, 32'h13, 32'd0);
    chk_all("lb13", 32'hFFFF_FFDE, 2'b00);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'd0);
    chk_all("lbu13", 32'h0000_00DE, 2'b00);
    xact("lh10", 1'b0, 3'b001, 32'h10, 32'd0);
    chk_all("lh10", 32'hFFFF_BEEF, 2'b00);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'd0);
    chk_all("lhu12", 32'h0000_DEAD, 2'b00);

    xact("sb11", 1'b1, 3'b000, 32'h11, 32'h55);
    xact("sh12", 1'b1, 3'b001, 32'h12, 32'h1234);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'd0);
    chk_all("lw10b", 32'h1234_55EF, 2'b00);

    xact("lw02", 1'b0, 3'b010, 32'h02, 32'd0);
    chk_all("lw02", 32'd0, 2'b01);
    xact("sw02", 1'b1, 3'b010, 32'h02, 32'hFFFF_FFFF);
    xact("lw00", 1'b0, 3'b010, 32'h00, 32'd0);
    xact("f3_011", 1'b0, 3'b011, 32'h10, 32'd0);
    chk_all("f3_011", 32'd0, 2'b01);
    xact("lw400", 1'b0, 3'b010, 32'h400, 32'd0);
    chk_all("lw400", 32'd0, 2'b10);
    xact("lh401", 1'b0, 3'b001, 32'h401, 32'd0);
    chk_all("lh401", 32'd0, 2'b11);
    xact("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D);
    xact("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'd0);
    chk_all("lw3fc", 32'hCAFE_F00D, 2'b00);

    // Held request: accepts only from IDLE, so done pulses are WAIT_STATES+3 apart.
    req = 1'b1; wr = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'd0;
    nd = '{0, 0, 0};
    for (int i = 0; i < 3; i++) t[i] = '{0, 0, 0};
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (done_o[i]) begin
          if (nd[i] < 3) t[i][nd[i]] = c;
          nd[i]++;
        end
      end
    end
    req = 1'b0;
    for (int c = 0; c < 20 && (busy_o[0] || busy_o[1] || busy_o[2]); c++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held gap1 u%0d", i), 32'(t[i][1] - t[i][0]), 32'(WS[i] + 3));
      chk($sformatf("held gap2 u%0d", i), 32'(t[i][2] - t[i][1]), 32'(WS[i] + 3));
      chk($sformatf("held drained u%0d", i), 32'(busy_o[i]), 32'd0);
    end

    // Reset lands on the edge that would commit the store in each instance.
    req = 1'b1; wr = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (k == WS[i]) begin
          chk($sformatf("pre_rst busy u%0d", i), 32'(busy_o[i]), 32'd1);
          rst[i] = 1'b1;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (k == WS[i]) begin
          chk($sformatf("mid_rst busy u%0d", i), 32'(busy_o[i]), 32'd0);
          chk($sformatf("mid_rst done u%0d", i), 32'(done_o[i]), 32'd0);
          chk($sformatf("mid_rst err u%0d", i), 32'(err_o[i]), 32'd0);
          chk($sformatf("mid_rst rdata u%0d", i), rdata_o[i], 32'd0);
          rst[i] = 1'b0;
        end
      end
    end
    xact("lw20_after_rst", 1'b0, 3'b010, 32'h20, 32'd0);

    for (int n = 0; n < 80; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rf3 = rw ? 3'($urandom_range(0, 2)) : ((rf3 == 3'd3) ? 3'd4 : (rf3 > 3'd5 ? 3'd1 : rf3));
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = 32'h400 + 32'($urandom_range(0, 63));
      else if (sel == 1) ra = 32'h3FC + 32'($urandom_range(0, 3));
      else               ra = 32'($urandom_range(0, 63));
      xact($sformatf("rnd%0d", n), rw, rf3, ra, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
